// File: rtl/uart_rx.sv
// UART receive front end: 16x oversampled deframer feeding the receive FIFO.
// Samples mid-bit, checks even parity and stop bits, and drives RTS from FIFO_Full.
module uart_rx #(
    parameter int unsigned SYSCLK_RATE = 100000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY_BIT  = 1,
    parameter int unsigned STOP_BITS   = 2
) (
    input  logic                 SysClk,
    input  logic                 Rst,
    input  logic                 Rx,
    input  logic                 FIFO_Full,
    output logic [DATA_BITS-1:0] Rx_Data,
    output logic                 Rx_Valid,
    output logic [2:0]           Rx_Error,
    output logic                 Rx_Busy,
    output logic                 RTS
);

    localparam int unsigned Div  = SYSCLK_RATE / (BAUD_RATE * 16);
    localparam int unsigned DivW = (Div > 1) ? $clog2(Div) : 1;
    localparam logic [DivW-1:0] DivLast  = DivW'(Div - 1);
    localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StDone
    } state_e;

    state_e               state_q, state_d;
    logic                 rx_meta_q, rxs_q;
    logic [DivW-1:0]      div_q, div_d;
    logic [3:0]           tcnt_q, tcnt_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic [2:0]           err_q, err_d;
    logic                 busy_q;
    logic                 rts_q;
    logic                 tick;

    assign tick = (state_q != StIdle) && (div_q == DivLast);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        tcnt_d    = tcnt_q;
        bcnt_d    = bcnt_q;
        shreg_d   = shreg_q;
        par_err_d = par_err_q;
        frm_err_d = frm_err_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = err_q;

        // Divider is parked at zero while idle so the first tick lands Div clocks after the edge.
        if (state_q == StIdle || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                tcnt_d = '0;
                bcnt_d = '0;
                if (!rxs_q) begin
                    state_d   = StStart;
                    par_err_d = 1'b0;
                    frm_err_d = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    if (tcnt_q == 4'd7) begin
                        tcnt_d = '0;
                        state_d = rxs_q ? StIdle : StData;
                    end else begin
                        tcnt_d = tcnt_q + 4'd1;
                    end
                end
            end
            StData: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        shreg_d = {rxs_q, shreg_q[DATA_BITS-1:1]};
                        if (bcnt_q == DataLast) begin
                            bcnt_d  = '0;
                            state_d = (PARITY_BIT != 0) ? StParity : StStop;
                        end else begin
                            bcnt_d = bcnt_q + 4'd1;
                        end
                    end
                end
            end
            StParity: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        par_err_d = (^shreg_q) != rxs_q;
                        state_d   = StStop;
                    end
                end
            end
            StStop: begin
                if (tick) begin
                    tcnt_d = tcnt_q + 4'd1;
                    if (tcnt_q == 4'd15) begin
                        if (!rxs_q) begin
                            frm_err_d = 1'b1;
                        end
                        if (bcnt_q == StopLast) begin
                            bcnt_d  = '0;
                            state_d = StDone;
                        end else begin
                            bcnt_d = bcnt_q + 4'd1;
                        end
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                err_d   = {FIFO_Full, frm_err_q, par_err_q};
                // A full FIFO drops the word; only the overrun flag records it.
                if (!FIFO_Full) begin
                    valid_d = 1'b1;
                    data_d  = shreg_q;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge SysClk) begin
        if (!Rst) begin
            state_q   <= StIdle;
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            div_q     <= '0;
            tcnt_q    <= '0;
            bcnt_q    <= '0;
            shreg_q   <= '0;
            par_err_q <= 1'b0;
            frm_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            rts_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= Rx;
            rxs_q     <= rx_meta_q;
            div_q     <= div_d;
            tcnt_q    <= tcnt_d;
            bcnt_q    <= bcnt_d;
            shreg_q   <= shreg_d;
            par_err_q <= par_err_d;
            frm_err_q <= frm_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= (state_d != StIdle);
            rts_q     <= ~FIFO_Full;
        end
    end

    assign Rx_Data  = data_q;
    assign Rx_Valid = valid_q;
    assign Rx_Error = err_q;
    assign Rx_Busy  = busy_q;
    assign RTS      = rts_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frames are driven bit by bit, expected words are queued
// at send time and retired by a strobe monitor.
module tb_uart_rx;

    logic       SysClk = 1'b0;
    logic       Rst;
    logic       Rx;
    logic       FIFO_Full;
    logic [7:0] Rx_Data;
    logic       Rx_Valid;
    logic [2:0] Rx_Error;
    logic       Rx_Busy;
    logic       RTS;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;
    int v0;
    logic [2:0] e0;
    logic prev_v = 1'b0;
    logic [10:0] exp_q[$];

    uart_rx #(
        .SYSCLK_RATE(1600000),
        .BAUD_RATE  (10000)
    ) dut (
        .SysClk   (SysClk),
        .Rst      (Rst),
        .Rx       (Rx),
        .FIFO_Full(FIFO_Full),
        .Rx_Data  (Rx_Data),
        .Rx_Valid (Rx_Valid),
        .Rx_Error (Rx_Error),
        .Rx_Busy  (Rx_Busy),
        .RTS      (RTS)
    );

    always #5 SysClk = ~SysClk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge SysClk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        Rx = b;
        step(160);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                              input logic s2);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s1);
        send_bit(s2);
        Rx = 1'b1;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            step(1);
            n++;
        end
        chk(tag, exp_q.size(), 0);
    endtask

    // Strobe monitor: retires one scoreboard entry per Rx_Valid pulse.
    always @(negedge SysClk) begin
        if (Rx_Valid) begin
            logic [10:0] e;
            valid_cnt++;
            chk("valid_back_to_back", prev_v, 0);
            chk("strobe_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("strobe_data", Rx_Data, e[7:0]);
                chk("strobe_err", Rx_Error, e[10:8]);
            end
        end
        prev_v = Rx_Valid;
    end

    initial begin
        Rx = 1'b1;
        FIFO_Full = 1'b0;
        Rst = 1'b0;
        step(3);
        chk("rst_valid", Rx_Valid, 0);
        chk("rst_data", Rx_Data, 0);
        chk("rst_err", Rx_Error, 0);
        chk("rst_busy", Rx_Busy, 0);
        chk("rst_rts", RTS, 0);
        Rst = 1'b1;
        step(2);
        chk("rts_after_rst", RTS, 1);
        step(50);

        // 1: clean 0xA5
        v0 = valid_cnt;
        exp_q.push_back({3'b000, 8'hA5});
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        wait_drain("t1_drain");
        step(20);
        chk("t1_one_strobe", valid_cnt - v0, 1);
        chk("t1_busy", Rx_Busy, 0);
        chk("t1_data_hold", Rx_Data, 8'hA5);
        step(200);

        // 2: parity error
        v0 = valid_cnt;
        exp_q.push_back({3'b001, 8'hA5});
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1);
        wait_drain("t2_drain");
        step(20);
        chk("t2_one_strobe", valid_cnt - v0, 1);
        chk("t2_err_hold", Rx_Error, 3'b001);
        step(200);

        // 3: framing error on second stop bit
        v0 = valid_cnt;
        exp_q.push_back({3'b010, 8'h5A});
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0);
        wait_drain("t3_drain");
        step(200);
        chk("t3_one_strobe", valid_cnt - v0, 1);
        chk("t3_busy", Rx_Busy, 0);
        chk("t3_err_hold", Rx_Error, 3'b010);

        // 4: 40-clock glitch is a false start
        v0 = valid_cnt;
        e0 = Rx_Error;
        Rx = 1'b0;
        step(5);
        chk("t4_busy_high", Rx_Busy, 1);
        step(35);
        Rx = 1'b1;
        begin
            int n = 0;
            while (Rx_Busy && n < 50) begin
                step(1);
                n++;
            end
        end
        chk("t4_busy_return", Rx_Busy, 0);
        step(200);
        chk("t4_no_strobe", valid_cnt - v0, 0);
        chk("t4_err_unchanged", Rx_Error, e0);

        // 5: overrun with FIFO full, then normal reception
        v0 = valid_cnt;
        FIFO_Full = 1'b1;
        step(2);
        chk("t5_rts_low", RTS, 0);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        step(20);
        chk("t5_no_strobe", valid_cnt - v0, 0);
        chk("t5_overrun", Rx_Error, 3'b100);
        FIFO_Full = 1'b0;
        step(2);
        chk("t5_rts_high", RTS, 1);
        v0 = valid_cnt;
        exp_q.push_back({3'b000, 8'h3C});
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        wait_drain("t5_drain");
        step(20);
        chk("t5_one_strobe", valid_cnt - v0, 1);
        chk("t5_err_clear", Rx_Error, 3'b000);
        chk("t5_rts_still", RTS, 1);
        step(200);

        // 6: reset during 4th data bit of 0xFF
        v0 = valid_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        Rx = 1'b1;
        step(80);
        Rst = 1'b0;
        step(1);
        chk("t6_rst_valid", Rx_Valid, 0);
        chk("t6_rst_data", Rx_Data, 0);
        chk("t6_rst_err", Rx_Error, 0);
        chk("t6_rst_busy", Rx_Busy, 0);
        chk("t6_rst_rts", RTS, 0);
        Rst = 1'b1;
        step(1400);
        chk("t6_no_strobe", valid_cnt - v0, 0);
        chk("t6_idle", Rx_Busy, 0);
        v0 = valid_cnt;
        exp_q.push_back({3'b000, 8'h81});
        send_frame(8'h81, 1'b0, 1'b1, 1'b1);
        wait_drain("t6_drain");
        step(20);
        chk("t6_one_strobe", valid_cnt - v0, 1);
        chk("t6_data", Rx_Data, 8'h81);
        chk("t6_err", Rx_Error, 3'b000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
